// File: rtl/membus_pkg.sv
// Shared widths and helpers for the membus arbiter slice.
// Pure definitions; no logic.
package membus_pkg;

    localparam int MEMBUS_ADDR_WIDTH = 20;
    // Matches the core's memory data width.
    localparam int MEMBUS_DATA_WIDTH = 64;

    function automatic int port_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/membus_id_fifo.sv
// Synchronous FIFO with a first-word fall-through head: rdata shows the oldest entry with no read latency.
// push is ignored while full, and pop is ignored while empty. full and empty come from the registered count.
module membus_id_fifo #(
    parameter int WIDTH      = 1,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = count[DEPTH_LOG2];
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + DEPTH_LOG2'(1);
            if (do_pop)  rptr <= rptr + DEPTH_LOG2'(1);
            count <= count + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/membus_arbiter.sv
// Round-robin, in-order merge of NUM_PORTS membus masters onto one slave, with responses routed back by an ID FIFO.
// Request and response paths are combinational. A stalled grant stays locked until it is accepted, and requests stop while the ID FIFO is full.
module membus_arbiter
    import membus_pkg::*;
#(
    parameter int NUM_PORTS     = 2,
    parameter int ADDR_WIDTH    = MEMBUS_ADDR_WIDTH,
    parameter int DATA_WIDTH    = MEMBUS_DATA_WIDTH,
    parameter int ID_DEPTH_LOG2 = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             m_valid,
    output logic [NUM_PORTS-1:0]             m_ready,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  m_addr,
    input  logic [NUM_PORTS-1:0]             m_wen,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  m_wdata,
    output logic [NUM_PORTS-1:0]             m_rvalid,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic                             s_valid,
    input  logic                             s_ready,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic                             s_wen,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    input  logic                             s_rvalid,
    input  logic [DATA_WIDTH-1:0]            s_rdata,
    output logic                             err
);
    localparam int IW = port_idx_width(NUM_PORTS);

    logic [IW-1:0] ptr;
    logic [IW-1:0] lk;
    logic          lock;
    logic [IW-1:0] gnt;
    logic [IW-1:0] head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          accept;

    // Later offsets are visited first so the nearest requester from start wins.
    function automatic logic [IW-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                              input logic [IW-1:0]        start);
        logic [IW-1:0] pick;
        int            idx;
        pick = start;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = (int'(start) + i) % NUM_PORTS;
            if (req[idx]) pick = IW'(idx);
        end
        return pick;
    endfunction

    assign gnt     = lock ? lk : rr_pick(m_valid, ptr);
    assign s_valid = (|m_valid) & ~fifo_full & ~rst;
    assign s_addr  = m_addr[gnt*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_wen   = m_wen[gnt];
    assign s_wdata = m_wdata[gnt*DATA_WIDTH +: DATA_WIDTH];
    assign accept  = s_valid & s_ready;
    assign m_rdata = s_rdata;

    always_comb begin
        m_ready = '0;
        if (!fifo_full && !rst) m_ready[gnt] = s_ready;
    end

    always_comb begin
        m_rvalid = '0;
        if (s_rvalid && !fifo_empty && !rst) m_rvalid[head] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr  <= '0;
            lk   <= '0;
            lock <= 1'b0;
            err  <= 1'b0;
        end else begin
            if (s_valid && !s_ready) begin
                lock <= 1'b1;
                lk   <= gnt;
            end else if (accept) begin
                lock <= 1'b0;
                ptr  <= (int'(gnt) == NUM_PORTS - 1) ? '0 : gnt + IW'(1);
            end
            if (s_rvalid && fifo_empty) err <= 1'b1;
        end
    end

    membus_id_fifo #(
        .WIDTH      (IW),
        .DEPTH_LOG2 (ID_DEPTH_LOG2)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (s_rvalid),
        .wdata (gnt),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_membus_arbiter.sv
// Bench for membus_arbiter: a directed vector table, a 3-port sequence, and random traffic checked against a queue model.
module tb_membus_arbiter;
    localparam int AW = 20;
    localparam int DW = 64;
    localparam logic [AW-1:0] A0 = 20'h00100;
    localparam logic [AW-1:0] A1 = 20'h00010;
    localparam logic [DW-1:0] D0 = 64'h1111_0000_0000_1111;
    localparam logic [DW-1:0] D1 = 64'h2222_0000_0000_2222;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0]      m_valid, m_ready, m_wen, m_rvalid;
    logic [2*AW-1:0] m_addr;
    logic [2*DW-1:0] m_wdata;
    logic [DW-1:0]   m_rdata, s_wdata, s_rdata;
    logic            s_valid, s_ready, s_wen, s_rvalid, err;
    logic [AW-1:0]   s_addr;

    logic [2:0]      m_valid3, m_ready3, m_wen3, m_rvalid3;
    logic [3*AW-1:0] m_addr3;
    logic [3*DW-1:0] m_wdata3;
    logic [DW-1:0]   m_rdata3, s_wdata3, s_rdata3;
    logic            s_valid3, s_ready3, s_wen3, s_rvalid3, err3;
    logic [AW-1:0]   s_addr3;

    int n_checks = 0;
    int n_fail   = 0;

    membus_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_DEPTH_LOG2(2)) dut (
        .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
        .m_wen(m_wen), .m_wdata(m_wdata), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wen(s_wen),
        .s_wdata(s_wdata), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .err(err));

    membus_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_DEPTH_LOG2(2)) dut3 (
        .clk(clk), .rst(rst), .m_valid(m_valid3), .m_ready(m_ready3), .m_addr(m_addr3),
        .m_wen(m_wen3), .m_wdata(m_wdata3), .m_rvalid(m_rvalid3), .m_rdata(m_rdata3),
        .s_valid(s_valid3), .s_ready(s_ready3), .s_addr(s_addr3), .s_wen(s_wen3),
        .s_wdata(s_wdata3), .s_rvalid(s_rvalid3), .s_rdata(s_rdata3), .err(err3));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  mv;
        logic        sr;
        logic        rv;
        logic [15:0] rd;
        logic        sv;
        logic [1:0]  mr;
        logic [1:0]  rvl;
        int          g;
        logic        e;
    } vec_t;
    vec_t vt[$];

    task automatic add(input logic r, input logic [1:0] mv, input logic sr, input logic rv,
                       input logic [15:0] rd, input logic sv, input logic [1:0] mr,
                       input logic [1:0] rvl, input int g, input logic e);
        vec_t x;
        x.rst = r; x.mv = mv; x.sr = sr; x.rv = rv; x.rd = rd;
        x.sv = sv; x.mr = mr; x.rvl = rvl; x.g = g; x.e = e;
        vt.push_back(x);
    endtask

    typedef struct {
        logic [2:0]  mv;
        logic        sr;
        logic        rv;
        logic [15:0] rd;
        logic        sv;
        logic [2:0]  mr;
        logic [2:0]  rvl;
        int          g;
    } vec3_t;
    vec3_t v3[6];

    // Random-phase state: master holding registers and the reference model.
    logic          held   [2];
    logic [AW-1:0] r_addr [2];
    logic          r_wen  [2];
    logic [DW-1:0] r_wdata[2];
    int            q[$];
    int            mptr, mlk, slave_out, g;
    bit            mlock, merr, full, esv;
    logic [1:0]    emr, ervl;

    initial begin
        rst = 1'b1;
        m_valid = '0; m_wen = 2'b01; s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        m_addr = {A1, A0}; m_wdata = {D1, D0};
        m_valid3 = '0; m_wen3 = 3'b101; s_ready3 = 1'b0; s_rvalid3 = 1'b0; s_rdata3 = '0;
        m_addr3 = {20'h30002, 20'h30001, 20'h30000};
        m_wdata3 = {64'hAAAA_0002, 64'hAAAA_0001, 64'hAAAA_0000};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Three ports, mixed read/write, each response two cycles after acceptance.
        v3[0] = '{3'b111, 1'b1, 1'b0, 16'h0000, 1'b1, 3'b001, 3'b000, 0};
        v3[1] = '{3'b110, 1'b1, 1'b0, 16'h0000, 1'b1, 3'b010, 3'b000, 1};
        v3[2] = '{3'b100, 1'b1, 1'b1, 16'h5000, 1'b1, 3'b100, 3'b001, 2};
        v3[3] = '{3'b000, 1'b0, 1'b1, 16'hBEEF, 1'b0, 3'b000, 3'b010, 0};
        v3[4] = '{3'b000, 1'b0, 1'b1, 16'h6000, 1'b0, 3'b000, 3'b100, 0};
        v3[5] = '{3'b000, 1'b0, 1'b0, 16'h0000, 1'b0, 3'b000, 3'b000, 0};
        for (int i = 0; i < 6; i++) begin
            m_valid3 = v3[i].mv; s_ready3 = v3[i].sr; s_rvalid3 = v3[i].rv;
            s_rdata3 = {48'h0, v3[i].rd};
            #2;
            chk($sformatf("p3 row%0d s_valid", i), s_valid3, v3[i].sv);
            chk($sformatf("p3 row%0d m_ready", i), m_ready3, v3[i].mr);
            chk($sformatf("p3 row%0d m_rvalid", i), m_rvalid3, v3[i].rvl);
            if (v3[i].sv) begin
                chk($sformatf("p3 row%0d s_addr", i), s_addr3, 20'h30000 + v3[i].g);
                chk($sformatf("p3 row%0d s_wen", i), s_wen3, (v3[i].g != 1));
            end
            if (v3[i].rvl == 3'b010) chk($sformatf("p3 row%0d read data", i), m_rdata3, 64'hBEEF);
            @(posedge clk);
            #1;
        end
        chk("p3 err", err3, 1'b0);

        // Two-port directed table: reset, single read, fairness, lock, full, error, reset mid-flight.
        add(1, 2'b11, 1, 0, 16'h0000, 0, 2'b00, 2'b00, 0, 0);
        add(0, 2'b10, 1, 0, 16'h0000, 1, 2'b10, 2'b00, 1, 0);
        add(0, 2'b00, 0, 1, 16'hDEAD, 0, 2'b00, 2'b10, 0, 0);
        add(0, 2'b11, 1, 0, 16'h0000, 1, 2'b01, 2'b00, 0, 0);
        add(0, 2'b11, 1, 0, 16'h0000, 1, 2'b10, 2'b00, 1, 0);
        add(0, 2'b11, 1, 1, 16'h00A0, 1, 2'b01, 2'b01, 0, 0);
        add(0, 2'b11, 1, 1, 16'h00A1, 1, 2'b10, 2'b10, 1, 0);
        add(0, 2'b00, 0, 1, 16'h00A2, 0, 2'b00, 2'b01, 0, 0);
        add(0, 2'b00, 0, 1, 16'h00A3, 0, 2'b00, 2'b10, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 2'b10, 0, 0, 16'h0000, 1, 2'b00, 2'b00, 1, 0);
        add(0, 2'b11, 0, 0, 16'h0000, 1, 2'b00, 2'b00, 1, 0);
        add(0, 2'b11, 1, 0, 16'h0000, 1, 2'b10, 2'b00, 1, 0);
        add(0, 2'b01, 1, 0, 16'h0000, 1, 2'b01, 2'b00, 0, 0);
        add(0, 2'b00, 0, 1, 16'h00B0, 0, 2'b00, 2'b10, 0, 0);
        add(0, 2'b00, 0, 1, 16'h00B1, 0, 2'b00, 2'b01, 0, 0);
        add(0, 2'b11, 1, 0, 16'h0000, 1, 2'b10, 2'b00, 1, 0);
        add(0, 2'b11, 1, 0, 16'h0000, 1, 2'b01, 2'b00, 0, 0);
        add(0, 2'b11, 1, 0, 16'h0000, 1, 2'b10, 2'b00, 1, 0);
        add(0, 2'b11, 1, 0, 16'h0000, 1, 2'b01, 2'b00, 0, 0);
        add(0, 2'b11, 1, 0, 16'h0000, 0, 2'b00, 2'b00, 0, 0);
        add(0, 2'b11, 1, 1, 16'h00C0, 0, 2'b00, 2'b10, 0, 0);
        add(0, 2'b11, 1, 0, 16'h0000, 1, 2'b10, 2'b00, 1, 0);
        add(0, 2'b00, 0, 1, 16'h00C1, 0, 2'b00, 2'b01, 0, 0);
        add(0, 2'b00, 0, 1, 16'h00C2, 0, 2'b00, 2'b10, 0, 0);
        add(0, 2'b00, 0, 1, 16'h00C3, 0, 2'b00, 2'b01, 0, 0);
        add(0, 2'b00, 0, 1, 16'h00C4, 0, 2'b00, 2'b10, 0, 0);
        add(0, 2'b00, 0, 1, 16'h00E0, 0, 2'b00, 2'b00, 0, 0);
        add(0, 2'b00, 0, 0, 16'h0000, 0, 2'b00, 2'b00, 0, 1);
        add(0, 2'b10, 1, 0, 16'h0000, 1, 2'b10, 2'b00, 1, 1);
        add(0, 2'b01, 1, 0, 16'h0000, 1, 2'b01, 2'b00, 0, 1);
        add(1, 2'b11, 1, 0, 16'h0000, 0, 2'b00, 2'b00, 0, 1);
        add(0, 2'b00, 0, 1, 16'h00F0, 0, 2'b00, 2'b00, 0, 0);
        add(0, 2'b11, 1, 0, 16'h0000, 1, 2'b01, 2'b00, 0, 1);
        add(0, 2'b00, 0, 1, 16'h00F1, 0, 2'b00, 2'b01, 0, 1);

        foreach (vt[i]) begin
            rst = vt[i].rst; m_valid = vt[i].mv; s_ready = vt[i].sr;
            s_rvalid = vt[i].rv; s_rdata = {48'h0, vt[i].rd};
            #2;
            chk($sformatf("row%0d s_valid", i), s_valid, vt[i].sv);
            chk($sformatf("row%0d m_ready", i), m_ready, vt[i].mr);
            chk($sformatf("row%0d m_rvalid", i), m_rvalid, vt[i].rvl);
            chk($sformatf("row%0d err", i), err, vt[i].e);
            if (vt[i].sv) begin
                chk($sformatf("row%0d s_addr", i), s_addr, (vt[i].g == 1) ? A1 : A0);
                chk($sformatf("row%0d s_wen", i), s_wen, (vt[i].g == 0));
                chk($sformatf("row%0d s_wdata", i), s_wdata, (vt[i].g == 1) ? D1 : D0);
            end
            if (vt[i].rvl != 2'b00) chk($sformatf("row%0d m_rdata", i), m_rdata, {48'h0, vt[i].rd});
            @(posedge clk);
            #1;
        end

        // Random traffic against the queue-based model.
        rst = 1'b1; m_valid = '0; s_ready = 1'b0; s_rvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        mptr = 0; mlock = 0; mlk = 0; merr = 0; slave_out = 0;
        for (int p = 0; p < 2; p++) begin
            held[p] = 1'b0; r_addr[p] = '0; r_wen[p] = 1'b0; r_wdata[p] = '0;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!held[p] && $urandom_range(0, 2) == 0) begin
                    held[p] = 1'b1;
                    r_addr[p] = AW'($urandom);
                    r_wen[p] = 1'($urandom);
                    r_wdata[p] = {$urandom, $urandom};
                end
                m_valid[p] = held[p];
            end
            m_addr = {r_addr[1], r_addr[0]};
            m_wen = {r_wen[1], r_wen[0]};
            m_wdata = {r_wdata[1], r_wdata[0]};
            s_ready = ($urandom_range(0, 3) != 0);
            s_rvalid = (slave_out > 0) && ($urandom_range(0, 1) == 1);
            s_rdata = {$urandom, $urandom};
            #2;
            g = mptr;
            if (mlock) g = mlk;
            else if (m_valid[mptr]) g = mptr;
            else if (m_valid[(mptr + 1) % 2]) g = (mptr + 1) % 2;
            full = (q.size() == 4);
            esv = (m_valid != 2'b00) && !full;
            emr = '0;
            if (!full && s_ready) emr[g] = 1'b1;
            ervl = '0;
            if (s_rvalid && q.size() > 0) ervl[q[0]] = 1'b1;
            chk($sformatf("rnd%0d s_valid", cyc), s_valid, esv);
            chk($sformatf("rnd%0d m_ready", cyc), m_ready, emr);
            chk($sformatf("rnd%0d m_rvalid", cyc), m_rvalid, ervl);
            chk($sformatf("rnd%0d err", cyc), err, merr);
            if (esv) begin
                chk($sformatf("rnd%0d s_addr", cyc), s_addr, r_addr[g]);
                chk($sformatf("rnd%0d s_wen", cyc), s_wen, r_wen[g]);
                chk($sformatf("rnd%0d s_wdata", cyc), s_wdata, r_wdata[g]);
            end
            if (ervl != 2'b00) chk($sformatf("rnd%0d m_rdata", cyc), m_rdata, s_rdata);
            if (s_rvalid) begin
                if (q.size() > 0) void'(q.pop_front());
                else merr = 1;
                slave_out--;
            end
            if (esv && s_ready) begin
                q.push_back(g);
                mptr = (g + 1) % 2;
                mlock = 0;
                slave_out++;
            end else if (esv) begin
                mlock = 1;
                mlk = g;
            end
            for (int p = 0; p < 2; p++) if (held[p] && emr[p]) held[p] = 1'b0;
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
